dcache_controller: RTL

- Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage (EX/MEM address, store data, MemRead/MemWrite) and a slow 256-bit-line backing memory.
- Hits complete in the same cycle with no stall.
- Misses raise stall_o, which the CPU uses to freeze the PC and all pipeline registers.
- The block runs the victim write-back and line refill over a req/ack handshake.

---
 rtl/dcache_controller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache between the CPU MEM stage and a 256-bit-line memory.
// Latency: hits return in the same cycle; a clean miss stalls 1 + fetch + 1 cycles, a dirty miss adds write-back.
// Backpressure: stall_o freezes the CPU during a miss; the memory side uses a req/ack handshake of unbounded latency.
// Optional: define DCACHE_STATS_EN to add hit_cnt_o/miss_cnt_o access counters.
module dcache_controller #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 22   // must equal 32 - INDEX_W - 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic         we_i,
  input  logic [31:0]  addr_i,
  input  logic [31:0]  data_i,
  output logic [31:0]  data_o,
  output logic         stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC, S_REFILL} state_e;

  state_e state_q, state_d;

  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [255:0]     line_q [LINES];

  // Only the line address of the missing access is kept; the word offset comes from the held request.
  logic [31:5] miss_addr_q, miss_addr_d;

  logic [2:0]         word;
  logic [INDEX_W-1:0] idx;
  logic [INDEX_W-1:0] m_idx;
  logic [TAG_W-1:0]   tag;
  logic               is_idle;
  logic               hit;
  logic               miss;
  logic               wr_hit;
  logic               fill;
  logic               unused_addr_bits;

  assign word    = addr_i[4:2];
  assign idx     = addr_i[INDEX_W+4:5];
  assign tag     = addr_i[31:INDEX_W+5];
  assign m_idx   = miss_addr_q[INDEX_W+4:5];
  assign is_idle = (state_q == S_IDLE);

  // Lookups are only honoured in IDLE and never while reset is held.
  assign hit    = rst_i & is_idle & req_i & valid_q[idx] & (tag_q[idx] == tag);
  assign miss   = rst_i & is_idle & req_i & ~hit;
  assign wr_hit = hit & we_i;
  assign fill   = rst_i & (state_q == S_ALLOC) & mem_ack_i;

  // Byte offset is always zero for word-aligned accesses.
  assign unused_addr_bits = ^addr_i[1:0];

  // State register with synchronous active-low reset; reset abandons any transfer in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: dirty victims are written back before the refill fetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (miss) state_d = (valid_q[idx] & dirty_q[idx]) ? S_WB : S_ALLOC;
      S_WB:     if (mem_ack_i) state_d = S_ALLOC;
      S_ALLOC:  if (mem_ack_i) state_d = S_REFILL;
      S_REFILL: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs: everything is forced low while reset is asserted.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (rst_i) begin
      case (state_q)
        S_WB: begin
          mem_req_o  = 1'b1;
          mem_we_o   = 1'b1;
          mem_addr_o = {tag_q[m_idx], m_idx, 5'b0};
          mem_data_o = line_q[m_idx];
        end
        S_ALLOC: begin
          mem_req_o  = 1'b1;
          mem_addr_o = {miss_addr_q, 5'b0};
        end
        default: ;
      endcase
    end
    data_o  = (hit & ~we_i) ? line_q[idx][{word, 5'b0} +: 32] : 32'h0;
    stall_o = rst_i & (miss | ~is_idle);
  end

  // Next values of line status bits and the captured miss address.
  always_comb begin
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    miss_addr_d = miss ? addr_i[31:5] : miss_addr_q;
    if (wr_hit) dirty_d[idx] = 1'b1;
    if (fill) begin
      valid_d[m_idx] = 1'b1;
      dirty_d[m_idx] = 1'b0;
    end
  end

  // Status registers; the tag and data arrays below carry no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q     <= '0;
      dirty_q     <= '0;
      miss_addr_q <= '0;
    end else begin
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Tag/data arrays: store hits merge one word, a refill replaces the whole line.
  always_ff @(posedge clk_i) begin
    if (wr_hit) line_q[idx][{word, 5'b0} +: 32] <= data_i;
    if (fill) begin
      line_q[m_idx] <= mem_data_i;
      tag_q[m_idx]  <= miss_addr_q[31:INDEX_W+5];
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  assign hit_cnt_d  = hit_cnt_q + 32'(hit);
  assign miss_cnt_d = miss_cnt_q + 32'(miss);

  // Access counters; the hit that follows every refill is counted as a hit as well.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
